// File: rtl/core_pkg.sv
// core_pkg: shared widths, stack geometry and opcode classes for the 4004 core.
package core_pkg;
    localparam int ADDR_W     = 12;
    localparam int STK_LEVELS = 3;
    localparam int SP_W       = $clog2(STK_LEVELS);
    localparam int DEPTH_W    = $clog2(STK_LEVELS + 1);

    typedef logic [ADDR_W-1:0] addr_t;

    // Upper opcode nibbles the decoder maps onto jmp_*/push/pop.
    typedef enum logic [3:0] {
        OPC_JCN     = 4'h1,
        OPC_JIN_FIN = 4'h3,
        OPC_JUN     = 4'h4,
        OPC_JMS     = 4'h5,
        OPC_ISZ     = 4'h7,
        OPC_BBL     = 4'hC
    } opc_e;

    function automatic addr_t page_target(input addr_t next_pc, input logic [7:0] lo);
        return {next_pc[ADDR_W-1:8], lo};
    endfunction
endpackage

// File: rtl/pc_stack_if.sv
// pc_stack_if: control/operand bundle from the decoder and pc/stack status back to it.
interface pc_stack_if;
    import core_pkg::*;
    logic               X3;
    logic               pc_inc;
    logic               jmp_long;
    logic               jmp_page;
    logic               jmp_ind;
    logic               push;
    logic               pop;
    logic [7:0]         opropa0;
    logic [7:0]         opropa1;
    logic [7:0]         rp;
    addr_t              pc;
    addr_t              pc_plus_one;
    logic [DEPTH_W-1:0] stk_depth;
    logic               stk_ovf;
    logic               stk_unf;

    modport master (
        output X3, pc_inc, jmp_long, jmp_page, jmp_ind, push, pop, opropa0, opropa1, rp,
        input  pc, pc_plus_one, stk_depth, stk_ovf, stk_unf
    );
    modport slave (
        input  X3, pc_inc, jmp_long, jmp_page, jmp_ind, push, pop, opropa0, opropa1, rp,
        output pc, pc_plus_one, stk_depth, stk_ovf, stk_unf
    );
endinterface

// File: rtl/pc_stack_addr_stack.sv
// addr_stack: circular return-address LIFO; overflow overwrites the oldest entry.
module addr_stack
    import core_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  addr_t              wdata_i,
    output addr_t              rdata_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               ovf_o,
    output logic               unf_o
);
    localparam logic [SP_W-1:0]    SP_TOP    = SP_W'(STK_LEVELS - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STK_LEVELS);

    addr_t              stk_q [STK_LEVELS];
    logic [SP_W-1:0]    sp_q, sp_d, sp_dec;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, unf_q, wr_en;

    // Pop dominates so a simultaneous push never writes the stack.
    assign wr_en = push_i & ~pop_i;

    always_comb begin
        sp_dec  = (sp_q == '0) ? SP_TOP : sp_q - 1'b1;
        sp_d    = pop_i ? sp_dec : wr_en ? ((sp_q == SP_TOP) ? '0 : sp_q + 1'b1) : sp_q;
        depth_d = pop_i ? ((depth_q == '0) ? '0 : depth_q - 1'b1)
                : wr_en ? ((depth_q == DEPTH_MAX) ? DEPTH_MAX : depth_q + 1'b1)
                : depth_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < STK_LEVELS; i++) stk_q[i] <= '0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= wr_en && (depth_q == DEPTH_MAX);
            unf_q   <= pop_i && (depth_q == '0);
            if (wr_en) stk_q[sp_q] <= wdata_i;
        end
    end

    assign rdata_o = stk_q[sp_dec];
    assign depth_o = depth_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;
endmodule

// File: rtl/pc_stack.sv
// pc_stack: 4004 program counter with priority next-pc mux and 3-level return stack.
module pc_stack
    import core_pkg::*;
(
    input  logic       CLK,
    input  logic       RES,
    pc_stack_if.slave  bus
);
    addr_t pc_q, pc_d, pc_plus_one, stk_rdata;
    logic  do_push, do_pop, unused_opc_hi;

    assign unused_opc_hi = ^bus.opropa0[7:4];
    assign pc_plus_one   = pc_q + 1'b1;
    assign do_pop        = bus.X3 & bus.pop;
    assign do_push       = bus.X3 & bus.push;

    // Priority: pop > push > jmp_long > jmp_ind > jmp_page > pc_inc; page jumps follow pc+1.
    always_comb begin
        pc_d = !bus.X3                    ? pc_q
             : bus.pop                    ? stk_rdata
             : (bus.push | bus.jmp_long)  ? {bus.opropa0[3:0], bus.opropa1}
             : bus.jmp_ind                ? page_target(pc_plus_one, bus.rp)
             : bus.jmp_page               ? page_target(pc_plus_one, bus.opropa1)
             : bus.pc_inc                 ? pc_plus_one
             : pc_q;
    end

    always_ff @(posedge CLK) begin
        if (RES) pc_q <= '0;
        else     pc_q <= pc_d;
    end

    addr_stack u_stack (
        .clk_i   (CLK),
        .rst_i   (RES),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .wdata_i (pc_plus_one),
        .rdata_o (stk_rdata),
        .depth_o (bus.stk_depth),
        .ovf_o   (bus.stk_ovf),
        .unf_o   (bus.stk_unf)
    );

    assign bus.pc          = pc_q;
    assign bus.pc_plus_one = pc_plus_one;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: scoreboard bench for pc_stack; each scenario task queues expectations and checks after the X3 edge.
module tb_pc_stack;
    import core_pkg::*;

    localparam logic [5:0] C_POP = 6'b100000, C_PUSH = 6'b010000, C_JL = 6'b001000;
    localparam logic [5:0] C_JI = 6'b000100, C_JP = 6'b000010, C_INC = 6'b000001, C_NONE = 6'b000000;

    typedef struct {
        logic       rst;
        logic       x3;
        logic [5:0] ctl;
        logic [7:0] o0, o1, r;
        logic [11:0] pc;
        logic [1:0] d;
        logic       ovf, unf;
    } step_t;

    logic CLK = 1'b0;
    logic RES = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    logic [15:0] sb [$];

    always #5 CLK = ~CLK;

    pc_stack_if bus ();
    pc_stack dut (.CLK(CLK), .RES(RES), .bus(bus));

    function automatic step_t st(input logic rst, input logic x3, input logic [5:0] ctl,
                                 input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] r,
                                 input logic [11:0] pc, input logic [1:0] d, input logic ovf, input logic unf);
        step_t s;
        s.rst = rst; s.x3 = x3; s.ctl = ctl; s.o0 = o0; s.o1 = o1; s.r = r;
        s.pc = pc; s.d = d; s.ovf = ovf; s.unf = unf;
        return s;
    endfunction

    task automatic drive(input step_t s);
        @(negedge CLK);
        RES = s.rst;
        bus.X3 = s.x3;
        {bus.pop, bus.push, bus.jmp_long, bus.jmp_ind, bus.jmp_page, bus.pc_inc} = s.ctl;
        bus.opropa0 = s.o0;
        bus.opropa1 = s.o1;
        bus.rp = s.r;
        @(posedge CLK);
        #1;
        RES = 1'b0;
        bus.X3 = 1'b0;
        {bus.pop, bus.push, bus.jmp_long, bus.jmp_ind, bus.jmp_page, bus.pc_inc} = C_NONE;
    endtask

    task automatic test_reset();
        step_t s [$];
        logic [15:0] got, want;
        s.push_back(st(1, 1, C_INC | C_JL, 8'h4F, 8'hFF, 8'h00, 12'h000, 0, 0, 0));
        s.push_back(st(1, 0, C_NONE, 8'h00, 8'h00, 8'h00, 12'h000, 0, 0, 0));
        foreach (s[i]) begin
            sb.push_back({s[i].pc, s[i].d, s[i].ovf, s[i].unf});
            drive(s[i]);
            got = {bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL reset step %0d: pc=%h d=%0d ovf=%b unf=%b, required pc=%h d=%0d ovf=%b unf=%b",
                         i, got[15:4], got[3:2], got[1], got[0], want[15:4], want[3:2], want[1], want[0]);
            end
        end
        checks++;
        if (bus.pc_plus_one !== 12'h001) begin
            fails++;
            $display("FAIL reset pc_plus_one: got %h required 001", bus.pc_plus_one);
        end
    endtask

    task automatic test_increment();
        step_t s [$];
        logic [15:0] got, want;
        for (int k = 1; k <= 5; k++) s.push_back(st(0, 1, C_INC, 8'h00, 8'h00, 8'h00, 12'(k), 0, 0, 0));
        for (int k = 0; k < 3; k++) s.push_back(st(0, 0, C_INC | C_JL | C_POP, 8'h4F, 8'hFF, 8'h00, 12'h005, 0, 0, 0));
        foreach (s[i]) begin
            sb.push_back({s[i].pc, s[i].d, s[i].ovf, s[i].unf});
            drive(s[i]);
            got = {bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL increment step %0d: pc=%h d=%0d ovf=%b unf=%b, required pc=%h d=%0d ovf=%b unf=%b",
                         i, got[15:4], got[3:2], got[1], got[0], want[15:4], want[3:2], want[1], want[0]);
            end
        end
        checks++;
        if (bus.pc_plus_one !== 12'h006) begin
            fails++;
            $display("FAIL increment pc_plus_one: got %h required 006", bus.pc_plus_one);
        end
    endtask

    task automatic test_wrap_page();
        step_t s [$];
        logic [15:0] got, want;
        s.push_back(st(0, 1, C_JL,  8'h4F, 8'hFF, 8'h00, 12'hFFF, 0, 0, 0));
        s.push_back(st(0, 1, C_INC, 8'h00, 8'h00, 8'h00, 12'h000, 0, 0, 0));
        s.push_back(st(0, 1, C_JL,  8'h42, 8'hFF, 8'h00, 12'h2FF, 0, 0, 0));
        s.push_back(st(0, 1, C_JP,  8'h00, 8'h34, 8'h00, 12'h334, 0, 0, 0));
        foreach (s[i]) begin
            sb.push_back({s[i].pc, s[i].d, s[i].ovf, s[i].unf});
            drive(s[i]);
            got = {bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL wrap_page step %0d: pc=%h d=%0d ovf=%b unf=%b, required pc=%h d=%0d ovf=%b unf=%b",
                         i, got[15:4], got[3:2], got[1], got[0], want[15:4], want[3:2], want[1], want[0]);
            end
            if (i == 0) begin
                checks++;
                if (bus.pc_plus_one !== 12'h000) begin
                    fails++;
                    $display("FAIL wrap pc_plus_one: got %h required 000", bus.pc_plus_one);
                end
            end
        end
    endtask

    task automatic test_jms_chain();
        step_t s [$];
        logic [15:0] got, want;
        s.push_back(st(0, 1, C_JL,   8'h40, 8'h10, 8'h00, 12'h010, 0, 0, 0));
        s.push_back(st(0, 1, C_PUSH, 8'h51, 8'h23, 8'h00, 12'h123, 1, 0, 0));
        s.push_back(st(0, 1, C_PUSH, 8'h52, 8'h00, 8'h00, 12'h200, 2, 0, 0));
        s.push_back(st(0, 1, C_PUSH, 8'h53, 8'h00, 8'h00, 12'h300, 3, 0, 0));
        s.push_back(st(0, 1, C_POP,  8'h00, 8'h00, 8'h00, 12'h201, 2, 0, 0));
        s.push_back(st(0, 1, C_POP,  8'h00, 8'h00, 8'h00, 12'h124, 1, 0, 0));
        s.push_back(st(0, 1, C_POP,  8'h00, 8'h00, 8'h00, 12'h011, 0, 0, 0));
        foreach (s[i]) begin
            sb.push_back({s[i].pc, s[i].d, s[i].ovf, s[i].unf});
            drive(s[i]);
            got = {bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL jms_chain step %0d: pc=%h d=%0d ovf=%b unf=%b, required pc=%h d=%0d ovf=%b unf=%b",
                         i, got[15:4], got[3:2], got[1], got[0], want[15:4], want[3:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_overflow();
        step_t s [$];
        logic [15:0] got, want;
        s.push_back(st(0, 1, C_JL,   8'h41, 8'h00, 8'h00, 12'h100, 0, 0, 0));
        s.push_back(st(0, 1, C_PUSH, 8'h54, 8'h00, 8'h00, 12'h400, 1, 0, 0));
        s.push_back(st(0, 1, C_PUSH, 8'h55, 8'h00, 8'h00, 12'h500, 2, 0, 0));
        s.push_back(st(0, 1, C_PUSH, 8'h56, 8'h00, 8'h00, 12'h600, 3, 0, 0));
        s.push_back(st(0, 1, C_PUSH, 8'h57, 8'h00, 8'h00, 12'h700, 3, 1, 0));
        s.push_back(st(0, 0, C_PUSH, 8'h58, 8'h00, 8'h00, 12'h700, 3, 0, 0));
        s.push_back(st(0, 1, C_POP,  8'h00, 8'h00, 8'h00, 12'h601, 2, 0, 0));
        s.push_back(st(0, 1, C_POP,  8'h00, 8'h00, 8'h00, 12'h501, 1, 0, 0));
        s.push_back(st(0, 1, C_POP,  8'h00, 8'h00, 8'h00, 12'h401, 0, 0, 0));
        foreach (s[i]) begin
            sb.push_back({s[i].pc, s[i].d, s[i].ovf, s[i].unf});
            drive(s[i]);
            got = {bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL overflow step %0d: pc=%h d=%0d ovf=%b unf=%b, required pc=%h d=%0d ovf=%b unf=%b",
                         i, got[15:4], got[3:2], got[1], got[0], want[15:4], want[3:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_underflow_jin();
        step_t s [$];
        logic [15:0] got, want;
        s.push_back(st(0, 1, C_POP,  8'h00, 8'h00, 8'h00, 12'h601, 0, 0, 1));
        s.push_back(st(0, 0, C_POP,  8'h00, 8'h00, 8'h00, 12'h601, 0, 0, 0));
        s.push_back(st(0, 1, C_JL,   8'h45, 8'hA0, 8'h00, 12'h5A0, 0, 0, 0));
        s.push_back(st(0, 1, C_JI,   8'h00, 8'h00, 8'hC7, 12'h5C7, 0, 0, 0));
        foreach (s[i]) begin
            sb.push_back({s[i].pc, s[i].d, s[i].ovf, s[i].unf});
            drive(s[i]);
            got = {bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL underflow_jin step %0d: pc=%h d=%0d ovf=%b unf=%b, required pc=%h d=%0d ovf=%b unf=%b",
                         i, got[15:4], got[3:2], got[1], got[0], want[15:4], want[3:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_priority();
        step_t s [$];
        logic [15:0] got, want;
        s.push_back(st(0, 1, C_POP | C_PUSH | C_INC,           8'h5F, 8'hEE, 8'h00, 12'h501, 0, 0, 1));
        s.push_back(st(0, 1, C_PUSH | C_JL | C_JI | C_JP | C_INC, 8'h46, 8'h78, 8'h99, 12'h678, 1, 0, 0));
        s.push_back(st(0, 1, C_JL | C_JI | C_JP | C_INC,        8'h4A, 8'h11, 8'h22, 12'hA11, 1, 0, 0));
        s.push_back(st(0, 1, C_JI | C_JP | C_INC,               8'h00, 8'h33, 8'h22, 12'hA22, 1, 0, 0));
        s.push_back(st(0, 1, C_JP | C_INC,                      8'h00, 8'h44, 8'h00, 12'hA44, 1, 0, 0));
        s.push_back(st(0, 1, C_POP,                             8'h00, 8'h00, 8'h00, 12'h502, 0, 0, 0));
        foreach (s[i]) begin
            sb.push_back({s[i].pc, s[i].d, s[i].ovf, s[i].unf});
            drive(s[i]);
            got = {bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL priority step %0d: pc=%h d=%0d ovf=%b unf=%b, required pc=%h d=%0d ovf=%b unf=%b",
                         i, got[15:4], got[3:2], got[1], got[0], want[15:4], want[3:2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_reset_override();
        step_t s [$];
        logic [15:0] got, want;
        s.push_back(st(1, 1, C_JL,   8'h4F, 8'hFF, 8'h00, 12'h000, 0, 0, 0));
        s.push_back(st(0, 1, C_PUSH, 8'h4B, 8'h00, 8'h00, 12'hB00, 1, 0, 0));
        s.push_back(st(1, 1, C_PUSH, 8'h4C, 8'h00, 8'h00, 12'h000, 0, 0, 0));
        s.push_back(st(0, 1, C_POP,  8'h00, 8'h00, 8'h00, 12'h000, 0, 0, 1));
        foreach (s[i]) begin
            sb.push_back({s[i].pc, s[i].d, s[i].ovf, s[i].unf});
            drive(s[i]);
            got = {bus.pc, bus.stk_depth, bus.stk_ovf, bus.stk_unf};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL reset_override step %0d: pc=%h d=%0d ovf=%b unf=%b, required pc=%h d=%0d ovf=%b unf=%b",
                         i, got[15:4], got[3:2], got[1], got[0], want[15:4], want[3:2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.X3 = 1'b0;
        {bus.pop, bus.push, bus.jmp_long, bus.jmp_ind, bus.jmp_page, bus.pc_inc} = C_NONE;
        bus.opropa0 = 8'h00;
        bus.opropa1 = 8'h00;
        bus.rp = 8'h00;
        test_reset();
        test_increment();
        test_wrap_page();
        test_jms_chain();
        test_overflow();
        test_underflow_jin();
        test_priority();
        test_reset_override();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Program counter and 3-level address stack for the 4004 core; directly upstream of the register file.
- Produces pc and pc_plus_one, which the register file muxes onto the ROM address nibbles (A1/A2/A3) and uses for FIN page selection.
- Executes sequential increment, long jumps (JUN/JMS), in-page jumps (JCN/ISZ), indirect jumps (JIN from the register pair rp) and subroutine return (BBL).
- Updates are taken only in the X3 phase.

Parameters:
- ADDR_W, 12, width of pc and stack entries. Behaviour below is defined for 12.
- STK_LEVELS, 3, number of stack entries. Wrap rules below are defined for 3.

Ports:
- CLK  input  1  system clock.
- RES  input  1  synchronous reset, active-high.
- X3  input  1  last-phase strobe from the timing generator; qualifies every update.
- pc_inc  input  1  advance pc by one at the end of this instruction word.
- jmp_long  input  1  JUN: pc <= {opropa0[3:0], opropa1}.
- jmp_page  input  1  JCN taken / ISZ taken: pc <= {pc_plus_one[11:8], opropa1}.
- jmp_ind  input  1  JIN: pc <= {pc_plus_one[11:8], rp}.
- push  input  1  JMS: save return address, then jump long.
- pop  input  1  BBL: pc <= top of stack.
- opropa0  input  8  first instruction word from the decoder.
- opropa1  input  8  second instruction word from the decoder.
- rp  input  8  register pair read from the register file.
- pc  output  12  current program counter.
- pc_plus_one  output  12  pc+1, combinational, modulo 4096.
- stk_depth  output  2  valid stack entries, 0..3, saturating.
- stk_ovf  output  1  one-cycle pulse: push issued while stk_depth==3.
- stk_unf  output  1  one-cycle pulse: pop issued while stk_depth==0.

Behaviour:
- Reset, synchronous, RES high at a CLK edge:
  - pc=0, sp=0, stk_depth=0, all stack entries=0, stk_ovf=0, stk_unf=0.
  - Reset overrides any control active in the same cycle.
  - Reset mid-instruction abandons the instruction; no partial update survives.
- All state changes occur at a CLK edge where X3=1. With X3=0 all controls are ignored and state holds.
- pc_plus_one = pc + 1, truncated to 12 bits, so 0xFFF -> 0x000. pc increment wraps the same way.
- Priority when several controls are active in one X3 cycle: pop > push > jmp_long > jmp_ind > jmp_page > pc_inc. Only the winner acts.
- pc_inc: pc <= pc_plus_one.
- jmp_page / jmp_ind page rule:
  - The decoder asserts these in X3 of the second word, while pc still addresses the second byte.
  - The target page is pc_plus_one[11:8].
  - So a jump whose second byte sits at xFF lands in the next page, matching the FIN page rule.
- push:
  - stack[sp] <= pc_plus_one; sp <= (sp==2) ? 0 : sp+1.
  - pc <= {opropa0[3:0], opropa1}.
  - stk_depth <= min(stk_depth+1, 3).
  - At stk_depth==3 the oldest entry is overwritten and stk_ovf pulses.
- pop:
  - sp <= (sp==0) ? 2 : sp-1; pc <= stack[that new sp].
  - stk_depth <= max(stk_depth-1, 0).
  - At stk_depth==0 the wrapped entry is still loaded and stk_unf pulses.
  - Stack contents are not cleared by pop.
- stk_ovf and stk_unf are registered and high for exactly the one cycle after the offending edge.
- No control in an X3 cycle: pc holds. The decoder holds pc_inc low during the FIN data-fetch cycle.
- Single-cycle latency: new pc is visible on the clock after the X3 edge, before the next A1.

Decomposition:
- Shared package core_pkg:
  - ADDR_W and STK_LEVELS.
  - Opcode-class constants used by the decoder to drive jmp_*/push/pop (JUN=4'h4, JMS=4'h5, JCN=4'h1, ISZ=4'h7, JIN/FIN=4'h3, BBL=4'hC).
- One natural sub-module: addr_stack (3-entry circular LIFO with sp, depth, ovf/unf).
- pc_stack keeps the pc register and the priority mux.

Test Plan:
- Reset, then 5 X3 cycles with pc_inc=1 -> pc=0x005, pc_plus_one=0x006. Toggling pc_inc with X3=0 -> pc unchanged.
- pc=0xFFF, pc_inc at X3 -> pc=0x000. pc=0x2FF, jmp_page with opropa1=0x34 -> pc=0x334 (next page).
- JMS chain:
  - pc=0x010, push, opropa0=0x51, opropa1=0x23 -> pc=0x123, stk_depth=1.
  - Two more pushes -> stk_depth=3.
  - Three pops -> pc returns 0x?+1 values in reverse order, ending at 0x011, stk_depth=0.
- Four pushes -> stk_ovf one-cycle pulse on the 4th, stk_depth=3. Then a pop returns the 4th push's return address.
- Pop at stk_depth=0 -> stk_unf pulse, stk_depth stays 0. Then jmp_ind with pc=0x5A0, rp=0xC7 -> pc=0x5C7.
- Simultaneous pop+push+pc_inc at X3 -> only the pop takes effect. RES asserted together with jmp_long -> pc=0x000, stk_depth=0.
